usb_bulk_txn_ctrl: RTL and testbench
====================================

// Module: usb_bulk_txn_ctrl
// PURPOSE
//   Device-side transaction sequencer for the bulk endpoint. It sits above USB_rx and the USB transmitter.
//   It enables the receiver, classifies each received packet (token/data/handshake) and decides the response.
//   It starts ACK/NAK/DATAx transmissions, maintains the DATA0/DATA1 toggle and enforces turnaround timeouts.
//   It commits or discards receive-FIFO data per transaction.
// PARAMETERS
//   TIMEOUT_CYC  144  idle clk cycles (no rcving) allowed while awaiting DATA or handshake (18 bit times x 8)
//   CNT_W        8    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//   clk          in   1  system clock; one clock domain only
//   rst          in   1  synchronous, active-high reset
//   en           in   1  endpoint enable
//   pckt_rcvd    in   1  1-cycle pulse from USB_rx: packet complete; pid/crc_ok/addr_match valid this cycle
//   rcvd_pid     in   4  PID nibble of completed packet
//   crc_ok       in   1  CRC5/CRC16 check passed
//   addr_match   in   1  token address/endpoint matches this device (ignored for non-token PIDs)
//   rcving       in   1  USB_rx is mid-packet
//   fifo_full    in   1  receive FIFO cannot accept a max-size packet
//   data_ready   in   1  transmit data packet staged for an IN token
//   tx_done      in   1  1-cycle pulse: transmitter finished the current packet incl. EOP
//   rx_en        out  1  receiver enable
//   hs_rcv       out  1  receiver should expect a handshake packet
//   read_done    out  1  1-cycle pulse: packet consumed, USB_rx may clear its status
//   tx_start     out  1  1-cycle pulse: start transmission of tx_pid
//   tx_pid       out  4  PID to transmit; held stable from tx_start until tx_done
//   data_commit  out  1  1-cycle pulse: keep the last received data packet in the FIFO
//   data_discard out  1  1-cycle pulse: roll back the last received data packet
//   data_toggle  out  1  expected DATAx sequence bit (0=DATA0)
//   txn_ok       out  1  1-cycle pulse: transaction completed successfully
//   txn_err      out  1  1-cycle pulse: transaction aborted
//   err_code     out  2  valid with txn_err: 0 TIMEOUT, 1 CRC, 2 PID, 3 reserved
// BEHAVIOUR
//   Reset: state IDLE. All outputs are 0, including data_toggle. tx_pid=4'h0. Timeout counter=0.
//     rst mid-transaction aborts immediately with no pulses.
//   All outputs are registered. Response pulses occur 1 cycle after the deciding pckt_rcvd/tx_done/timeout.
//   read_done pulses 1 cycle after every pckt_rcvd in every state, including ignored packets.
//   IDLE: rx_en=0. en=1 -> WAIT_TOKEN.
//   WAIT_TOKEN: rx_en=1, hs_rcv=0. en=0 -> IDLE. On pckt_rcvd with crc_ok and addr_match:
//     OUT -> WAIT_DATA, counter cleared.
//     IN with data_ready=1 -> SEND_DATA, tx_pid = data_toggle ? DATA1 : DATA0.
//     IN with data_ready=0 -> SEND_HS, tx_pid=NAK.
//     Any other PID, or a failing crc_ok/addr_match, is ignored silently; the state is held.
//   WAIT_DATA: rx_en=1. The counter increments each cycle rcving=0 and clears while rcving=1.
//     counter==TIMEOUT_CYC-1 -> txn_err, code TIMEOUT, -> WAIT_TOKEN.
//     On pckt_rcvd:
//       crc_ok=0 -> data_discard, txn_err CRC, no handshake, -> WAIT_TOKEN.
//       PID not DATA0/1 -> data_discard, txn_err PID, -> WAIT_TOKEN.
//       DATAx with x != data_toggle (duplicate) -> data_discard, tx ACK, toggle unchanged.
//       Correct DATAx with fifo_full=1 -> data_discard, tx NAK, toggle unchanged.
//       Correct DATAx with fifo_full=0 -> data_commit, tx ACK, toggle flips, txn_ok.
//       In all three DATAx cases -> SEND_HS.
//     If pckt_rcvd and timeout fall in the same cycle, the packet wins.
//   SEND_HS: rx_en=0. tx_start in the first cycle. tx_done -> WAIT_TOKEN (IDLE if en=0).
//   SEND_DATA: rx_en=0. tx_start in the first cycle. tx_done -> WAIT_HS, counter cleared.
//   WAIT_HS: rx_en=1, hs_rcv=1. Same timeout rule (txn_err TIMEOUT; toggle unchanged).
//     On pckt_rcvd:
//       ACK with crc_ok -> toggle flips, txn_ok.
//       NAK -> toggle unchanged, no pulse.
//       Anything else -> txn_err PID.
//     All of the above -> WAIT_TOKEN.
//   en deassertion outside WAIT_TOKEN is deferred until the transaction ends, then -> IDLE.
//   The counter saturates and never wraps. The toggle is only changed by the rules above or by rst.
// STRUCTURE
//   usb_pkg: PID localparams (OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010).
//     Also holds the state enum {IDLE, WAIT_TOKEN, WAIT_DATA, SEND_HS, SEND_DATA, WAIT_HS} and the err_code enum.
//   Sub-module usb_timeout_cnt (params TIMEOUT_CYC, CNT_W; ports clear, count_en, expired).
//   FSM, toggle and output registers live in this module.
// TESTING
//   1. OUT(addr_match,crc_ok), then DATA0 after 20 cycles, fifo_full=0
//      -> data_commit, tx_start with tx_pid=ACK, txn_ok; data_toggle 0->1.
//   2. Repeat DATA0 with data_toggle=1
//      -> data_discard, ACK sent, data_toggle stays 1, no txn_ok.
//   3. OUT then DATA1 with fifo_full=1
//      -> data_discard, tx_pid=NAK, toggle unchanged.
//   4. OUT, no rcving for 144 cycles
//      -> txn_err, err_code=0 on cycle 145, state WAIT_TOKEN, no tx_start.
//   5. IN with data_ready=1, tx_done, then ACK
//      -> tx_pid=DATA0, hs_rcv=1 in WAIT_HS, txn_ok, toggle 0->1.
//   6. IN with data_ready=0 -> NAK sent.
//      Token with addr_match=0 -> only read_done.
//      rst asserted in WAIT_HS -> all outputs 0 and toggle 0 the next cycle.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared PID codes, sequencer state encoding and error codes for the bulk endpoint.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TOKEN,
    WAIT_DATA,
    SEND_HS,
    SEND_DATA,
    WAIT_HS
  } state_e;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_PID     = 2'd2,
    ERR_RSVD    = 2'd3
  } err_e;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_timeout_cnt.sv
// Turnaround timeout counter: counts idle cycles while enabled, saturates at all-ones.
// expired flags the last allowed cycle so the owner can act on that edge.
module usb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 144,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/usb_bulk_txn_ctrl.sv
// Bulk endpoint transaction sequencer: token decode, DATAx toggle, handshake generation,
// turnaround timeouts and FIFO commit/discard. All outputs registered, one cycle after the cause.
module usb_bulk_txn_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 144,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pckt_rcvd,
  input  logic [3:0] rcvd_pid,
  input  logic       crc_ok,
  input  logic       addr_match,
  input  logic       rcving,
  input  logic       fifo_full,
  input  logic       data_ready,
  input  logic       tx_done,
  output logic       rx_en,
  output logic       hs_rcv,
  output logic       read_done,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       data_commit,
  output logic       data_discard,
  output logic       data_toggle,
  output logic       txn_ok,
  output logic       txn_err,
  output logic [1:0] err_code
);

  state_e     state_q, state_d;
  state_e     done_state;
  logic       rx_en_q, rx_en_d;
  logic       hs_rcv_q, hs_rcv_d;
  logic       read_done_q, read_done_d;
  logic       tx_start_q, tx_start_d;
  logic [3:0] tx_pid_q, tx_pid_d;
  logic       commit_q, commit_d;
  logic       discard_q, discard_d;
  logic       tog_q, tog_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  err_e       err_code_q, err_code_d;
  logic       cnt_clr;
  logic       waiting;
  logic       expired;

  assign waiting = (state_q == WAIT_DATA) || (state_q == WAIT_HS);

  usb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr || rcving),
    .count_en (waiting && !rcving),
    .expired  (expired)
  );

  always_comb begin
    state_d     = state_q;
    tog_d       = tog_q;
    tx_pid_d    = tx_pid_q;
    tx_start_d  = 1'b0;
    commit_d    = 1'b0;
    discard_d   = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = ERR_TIMEOUT;
    cnt_clr     = 1'b0;
    read_done_d = pckt_rcvd;
    // A disable that arrived mid-transaction takes effect where the transaction ends.
    done_state  = en ? WAIT_TOKEN : IDLE;

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_TOKEN;
      end
      WAIT_TOKEN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (pckt_rcvd && crc_ok && addr_match) begin
          if (rcvd_pid == PID_OUT) begin
            state_d = WAIT_DATA;
            cnt_clr = 1'b1;
          end else if (rcvd_pid == PID_IN) begin
            tx_start_d = 1'b1;
            if (data_ready) begin
              state_d  = SEND_DATA;
              tx_pid_d = tog_q ? PID_DATA1 : PID_DATA0;
            end else begin
              state_d  = SEND_HS;
              tx_pid_d = PID_NAK;
            end
          end
        end
      end
      WAIT_DATA: begin
        if (pckt_rcvd) begin
          if (!crc_ok) begin
            discard_d  = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_CRC;
            state_d    = done_state;
          end else if (!is_data_pid(rcvd_pid)) begin
            discard_d  = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_PID;
            state_d    = done_state;
          end else begin
            state_d    = SEND_HS;
            tx_start_d = 1'b1;
            if ((rcvd_pid == PID_DATA1) != tog_q) begin
              // Host missed our last ACK and resent: re-ACK, keep sequence.
              discard_d = 1'b1;
              tx_pid_d  = PID_ACK;
            end else if (fifo_full) begin
              discard_d = 1'b1;
              tx_pid_d  = PID_NAK;
            end else begin
              commit_d = 1'b1;
              tx_pid_d = PID_ACK;
              tog_d    = ~tog_q;
              ok_d     = 1'b1;
            end
          end
        end else if (expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = done_state;
        end
      end
      SEND_HS: begin
        if (tx_done) state_d = done_state;
      end
      SEND_DATA: begin
        if (tx_done) begin
          state_d = WAIT_HS;
          cnt_clr = 1'b1;
        end
      end
      WAIT_HS: begin
        if (pckt_rcvd) begin
          state_d = done_state;
          if ((rcvd_pid == PID_ACK) && crc_ok) begin
            tog_d = ~tog_q;
            ok_d  = 1'b1;
          end else if (rcvd_pid != PID_NAK) begin
            err_d      = 1'b1;
            err_code_d = ERR_PID;
          end
        end else if (expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = done_state;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_en_d  = (state_d == WAIT_TOKEN) || (state_d == WAIT_DATA) || (state_d == WAIT_HS);
    hs_rcv_d = (state_d == WAIT_HS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_en_q     <= 1'b0;
      hs_rcv_q    <= 1'b0;
      read_done_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_pid_q    <= 4'h0;
      commit_q    <= 1'b0;
      discard_q   <= 1'b0;
      tog_q       <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_TIMEOUT;
    end else begin
      state_q     <= state_d;
      rx_en_q     <= rx_en_d;
      hs_rcv_q    <= hs_rcv_d;
      read_done_q <= read_done_d;
      tx_start_q  <= tx_start_d;
      tx_pid_q    <= tx_pid_d;
      commit_q    <= commit_d;
      discard_q   <= discard_d;
      tog_q       <= tog_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rx_en        = rx_en_q;
  assign hs_rcv       = hs_rcv_q;
  assign read_done    = read_done_q;
  assign tx_start     = tx_start_q;
  assign tx_pid       = tx_pid_q;
  assign data_commit  = commit_q;
  assign data_discard = discard_q;
  assign data_toggle  = tog_q;
  assign txn_ok       = ok_q;
  assign txn_err      = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_usb_bulk_txn_ctrl.sv
// Directed bench for the bulk transaction sequencer with hand-computed expectations.
module tb_usb_bulk_txn_ctrl;

  localparam logic [3:0] OUT_P = 4'b0001;
  localparam logic [3:0] IN_P  = 4'b1001;
  localparam logic [3:0] D0_P  = 4'b0011;
  localparam logic [3:0] D1_P  = 4'b1011;
  localparam logic [3:0] ACK_P = 4'b0010;
  localparam logic [3:0] NAK_P = 4'b1010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pckt_rcvd = 1'b0;
  logic [3:0] rcvd_pid = 4'h0;
  logic       crc_ok = 1'b0;
  logic       addr_match = 1'b0;
  logic       rcving = 1'b0;
  logic       fifo_full = 1'b0;
  logic       data_ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_en, hs_rcv, read_done, tx_start;
  logic [3:0] tx_pid;
  logic       data_commit, data_discard, data_toggle, txn_ok, txn_err;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;

  usb_bulk_txn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pckt_rcvd    (pckt_rcvd),
    .rcvd_pid     (rcvd_pid),
    .crc_ok       (crc_ok),
    .addr_match   (addr_match),
    .rcving       (rcving),
    .fifo_full    (fifo_full),
    .data_ready   (data_ready),
    .tx_done      (tx_done),
    .rx_en        (rx_en),
    .hs_rcv       (hs_rcv),
    .read_done    (read_done),
    .tx_start     (tx_start),
    .tx_pid       (tx_pid),
    .data_commit  (data_commit),
    .data_discard (data_discard),
    .data_toggle  (data_toggle),
    .txn_ok       (txn_ok),
    .txn_err      (txn_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input logic [3:0] pid, input logic c, input logic a);
    pckt_rcvd  = 1'b1;
    rcvd_pid   = pid;
    crc_ok     = c;
    addr_match = a;
    tick();
    pckt_rcvd  = 1'b0;
    rcvd_pid   = 4'h0;
    crc_ok     = 1'b0;
    addr_match = 1'b0;
  endtask

  task automatic txd();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Packs the pulse outputs {commit,discard,ok,err,tx_start,read_done,rx_en,hs_rcv}.
  function automatic logic [7:0] pulses();
    return {data_commit, data_discard, txn_ok, txn_err, tx_start, read_done, rx_en, hs_rcv};
  endfunction

  initial begin
    tick();
    tick();
    chk("reset_outputs", pulses(), 8'b0000_0000);
    chk("reset_tx_pid", {4'h0, tx_pid}, 8'h00);
    chk("reset_toggle", {7'd0, data_toggle}, 8'h00);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk("idle_to_wait_token", pulses(), 8'b0000_0010);

    // 1: OUT then DATA0 accepted
    pkt(OUT_P, 1'b1, 1'b1);
    chk("t1_out", pulses(), 8'b0000_0110);
    repeat (20) tick();
    pkt(D0_P, 1'b1, 1'b0);
    chk("t1_data0", pulses(), 8'b1010_1100);
    chk("t1_pid", {4'h0, tx_pid}, {4'h0, ACK_P});
    chk("t1_toggle", {7'd0, data_toggle}, 8'h01);
    tick();
    chk("t1_pid_hold", {3'd0, tx_start, tx_pid}, {4'h0, ACK_P});
    txd();
    chk("t1_back_token", pulses(), 8'b0000_0010);

    // 2: duplicate DATA0
    pkt(OUT_P, 1'b1, 1'b1);
    pkt(D0_P, 1'b1, 1'b0);
    chk("t2_dup", pulses(), 8'b0100_1100);
    chk("t2_pid_tog", {3'd0, data_toggle, tx_pid}, {4'h1, ACK_P});
    txd();

    // 3: DATA1 with fifo full
    fifo_full = 1'b1;
    pkt(OUT_P, 1'b1, 1'b1);
    pkt(D1_P, 1'b1, 1'b0);
    fifo_full = 1'b0;
    chk("t3_full", pulses(), 8'b0100_1100);
    chk("t3_pid_tog", {3'd0, data_toggle, tx_pid}, {4'h1, NAK_P});
    txd();

    // 4: timeout after OUT
    pkt(OUT_P, 1'b1, 1'b1);
    repeat (143) tick();
    chk("t4_before_timeout", pulses(), 8'b0000_0010);
    tick();
    chk("t4_timeout", pulses(), 8'b0001_0010);
    chk("t4_err_code", {6'd0, err_code}, 8'h00);
    tick();
    chk("t4_err_pulse_end", pulses(), 8'b0000_0010);

    // CRC and PID errors while awaiting data
    pkt(OUT_P, 1'b1, 1'b1);
    pkt(D1_P, 1'b0, 1'b0);
    chk("crc_err", pulses(), 8'b0101_0110);
    chk("crc_code", {6'd0, err_code}, 8'h01);
    pkt(OUT_P, 1'b1, 1'b1);
    pkt(IN_P, 1'b1, 1'b1);
    chk("pid_err", pulses(), 8'b0101_0110);
    chk("pid_code", {6'd0, err_code}, 8'h02);
    chk("err_toggle", {7'd0, data_toggle}, 8'h01);

    // 5: IN with data, host ACK
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    data_ready = 1'b1;
    pkt(IN_P, 1'b1, 1'b1);
    chk("t5_in", pulses(), 8'b0000_1100);
    chk("t5_pid", {4'h0, tx_pid}, {4'h0, D0_P});
    txd();
    chk("t5_wait_hs", pulses(), 8'b0000_0011);
    pkt(ACK_P, 1'b1, 1'b0);
    chk("t5_ack", pulses(), 8'b0010_0110);
    chk("t5_toggle", {7'd0, data_toggle}, 8'h01);

    // 6: NAK for no data, address miss ignored, reset in WAIT_HS
    data_ready = 1'b0;
    pkt(IN_P, 1'b1, 1'b1);
    chk("t6_nak", pulses(), 8'b0000_1100);
    chk("t6_nak_pid", {4'h0, tx_pid}, {4'h0, NAK_P});
    txd();
    pkt(OUT_P, 1'b1, 1'b0);
    chk("t6_addr_miss", pulses(), 8'b0000_0110);
    data_ready = 1'b1;
    pkt(IN_P, 1'b1, 1'b1);
    chk("t6_data1_pid", {3'd0, tx_start, tx_pid}, {4'h1, D1_P});
    txd();
    chk("t6_in_wait_hs", pulses(), 8'b0000_0011);
    rst = 1'b1;
    tick();
    chk("t6_rst_outputs", pulses(), 8'b0000_0000);
    chk("t6_rst_pid_tog", {3'd0, data_toggle, tx_pid}, 8'h00);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
